// File: rtl/calc_op_sequencer.sv
// Multi-cycle ADD/SUB/MUL controller built around a single time-shared 8-bit adder.
// A MUL uses 8 shift-and-add passes through that adder.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; the request and operands are latched here
// EXEC  | adder busy: 1 cycle for ADD/SUB, MUL_STEPS cycles for MUL
// DONE  | one-cycle done pulse; result/flag/err already hold the new values

module adder_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [8:0] sum_o
);
  assign sum_o = {1'b0, a_i} + {1'b0, b_i} + {8'b0, cin_i};
endmodule

module calc_op_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [7:0]  opa,
  input  logic [7:0]  opb,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        flag,
  output logic        err
);
  localparam int MUL_STEPS = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [7:0]  m_q, q_q, acc_q;
  logic [2:0]  step_q;
  logic [15:0] result_q;
  logic        flag_q, err_q;

  logic [7:0]  add_a, add_b;
  logic        add_cin;
  logic [8:0]  add_sum;
  logic        last_step;

  adder_8bit u_adder (
    .a_i   (add_a),
    .b_i   (add_b),
    .cin_i (add_cin),
    .sum_o (add_sum)
  );

  // ADD/SUB use the latched operands; MUL adds the multiplicand into acc when Q[0] is set.
  always_comb begin
    add_a   = acc_q;
    add_b   = q_q[0] ? m_q : 8'h00;
    add_cin = 1'b0;
    if (op_q == OP_ADD) begin
      add_a = m_q;
      add_b = q_q;
    end else if (op_q == OP_SUB) begin
      add_a   = m_q;
      add_b   = ~q_q;
      add_cin = 1'b1;
    end
  end

  assign last_step = (op_q != OP_MUL) || (step_q == 3'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (op == OP_RSV) ? S_DONE : S_EXEC;
      S_EXEC:  if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_EXEC);
    done = (state_q == S_DONE);
  end

  // step_q counts down from MUL_STEPS-1; the pass taken with step_q==0 is the last one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= OP_ADD;
      m_q      <= 8'h00;
      q_q      <= 8'h00;
      acc_q    <= 8'h00;
      step_q   <= 3'd0;
      result_q <= 16'h0000;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            m_q    <= opa;
            q_q    <= opb;
            acc_q  <= 8'h00;
            step_q <= 3'(MUL_STEPS - 1);
            if (op == OP_RSV) begin
              result_q <= 16'h0000;
              flag_q   <= 1'b0;
              err_q    <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_ADD: begin
              result_q <= {7'b0, add_sum};
              flag_q   <= add_sum[8];
              err_q    <= 1'b0;
            end
            OP_SUB: begin
              result_q <= {8'b0, add_sum[7:0]};
              flag_q   <= ~add_sum[8];
              err_q    <= 1'b0;
            end
            OP_MUL: begin
              acc_q <= add_sum[8:1];
              q_q   <= {add_sum[0], q_q[7:1]};
              if (step_q == 3'd0) begin
                result_q <= {add_sum, q_q[7:1]};
                flag_q   <= |add_sum[8:1];
                err_q    <= 1'b0;
              end else begin
                step_q <= step_q - 3'd1;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign flag   = flag_q;
  assign err    = err_q;
endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: a behavioural model checks every cycle, and directed
// operations check their results against hand-computed values.
module tb_calc_op_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [7:0]  opa = 8'h00, opb = 8'h00;
  logic        busy, done, flag, err;
  logic [15:0] result;

  int n_checks = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  calc_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .flag(flag), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 busy, 2 done pulse. Outcomes come from plain arithmetic.
  int          m_phase = 0;
  int          m_left = 0;
  logic [15:0] m_res = 16'h0, p_res = 16'h0;
  logic        m_flag = 1'b0, p_flag = 1'b0, m_err = 1'b0, p_err = 1'b0;

  always @(posedge clk) begin
    int prod;
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_res = 16'h0; m_flag = 1'b0; m_err = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          p_err = 1'b0;
          case (op)
            2'd0: begin prod = int'(opa) + int'(opb); p_res = 16'(prod); p_flag = (prod > 255); end
            2'd1: begin prod = int'(opa) - int'(opb); p_res = 16'(prod & 255); p_flag = (opa < opb); end
            2'd2: begin prod = int'(opa) * int'(opb); p_res = 16'(prod); p_flag = (prod > 255); end
            default: begin p_res = 16'h0; p_flag = 1'b0; p_err = 1'b1; end
          endcase
          if (op == 2'd3) begin
            m_res = p_res; m_flag = p_flag; m_err = p_err; m_phase = 2;
          end else begin
            m_left = (op == 2'd2) ? 8 : 1;
            m_phase = 1;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_res = p_res; m_flag = p_flag; m_err = p_err; m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cmp busy", busy, m_phase == 1);
      chk("cmp done", done, m_phase == 2);
      chk("cmp result", result, m_res);
      chk("cmp flag", flag, m_flag);
      chk("cmp err", err, m_err);
    end
  end

  task automatic run_op(input string nm, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] er, input logic ef, input logic ee, input int lat);
    int  cyc, nbusy;
    bit  seen;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    cyc = 0; nbusy = 0; seen = 1'b0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0; opa = ~a; opb = ~b;
      end
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk({nm, " done seen"}, 32'(seen), 1);
    if (seen) begin
      chk({nm, " latency"}, cyc, lat);
      chk({nm, " busy cycles"}, nbusy, lat - 1);
      chk({nm, " result"}, result, er);
      chk({nm, " flag"}, flag, ef);
      chk({nm, " err"}, err, ee);
    end
  endtask

  initial begin
    int  cyc, nd;
    bit  seen;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    chk("reset flag", flag, 0);
    chk("reset err", err, 0);
    rst_n = 1'b1;

    run_op("add 200+100", 2'd0, 8'd200, 8'd100, 16'h012C, 1'b1, 1'b0, 2);
    run_op("sub 7-5",     2'd1, 8'd7,   8'd5,   16'h0002, 1'b0, 1'b0, 2);
    run_op("sub 5-7",     2'd1, 8'd5,   8'd7,   16'h00FE, 1'b1, 1'b0, 2);
    run_op("mul 255*255", 2'd2, 8'd255, 8'd255, 16'hFE01, 1'b1, 1'b0, 9);
    run_op("mul 15*0",    2'd2, 8'd15,  8'd0,   16'h0000, 1'b0, 1'b0, 9);
    run_op("mul 12*11",   2'd2, 8'd12,  8'd11,  16'h0084, 1'b0, 1'b0, 9);

    // start held high through a MUL while op/operands toggle
    @(negedge clk);
    start = 1'b1; op = 2'd2; opa = 8'd13; opb = 8'd17;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) seen = 1'b1;
      else begin
        op = 2'($urandom); opa = 8'($urandom); opb = 8'($urandom);
      end
    end
    chk("hold done seen", 32'(seen), 1);
    chk("hold latency", cyc, 9);
    chk("hold result", result, 16'h00DD);
    chk("hold flag", flag, 0);
    op = 2'd0; opa = 8'd1; opb = 8'd2;
    @(negedge clk);
    chk("b2b idle busy", busy, 0);
    chk("b2b idle done", done, 0);
    @(negedge clk);
    chk("b2b accepted busy", busy, 1);
    start = 1'b0;
    @(negedge clk);
    chk("b2b done", done, 1);
    chk("b2b result", result, 16'h0003);

    run_op("reserved op", 2'd3, 8'd9, 8'd4, 16'h0000, 1'b0, 1'b1, 1);
    run_op("add 1+1",     2'd0, 8'd1, 8'd1, 16'h0002, 1'b0, 1'b0, 2);

    // reset while MUL is at step 4
    @(negedge clk);
    start = 1'b1; op = 2'd2; opa = 8'd200; opb = 8'd201;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst mid busy before", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst mid busy", busy, 0);
    chk("rst mid done", done, 0);
    chk("rst mid result", result, 0);
    chk("rst mid flag", flag, 0);
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("rst no done pulse", nd, 0);

    run_op("mul 3*3", 2'd2, 8'd3, 8'd3, 16'h0009, 1'b0, 1'b0, 9);

    @(negedge clk);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
